// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - sample/status bundle for seq_detector_param (SEQ_DET_STICKY_EN adds seen)
interface seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int SW = $clog2(PAT_LEN);

    logic             en;
    logic             w;
    logic             overlap;
    logic             clr_cnt;
    logic             z;
    logic             z_reg;
    logic [CNT_W-1:0] match_count;
    logic [SW-1:0]    state_dbg;
`ifdef SEQ_DET_STICKY_EN
    logic             seen;

    modport master (
        output en, w, overlap, clr_cnt,
        input  z, z_reg, match_count, state_dbg, seen
    );
    modport slave (
        input  en, w, overlap, clr_cnt,
        output z, z_reg, match_count, state_dbg, seen
    );
`else
    modport master (
        output en, w, overlap, clr_cnt,
        input  z, z_reg, match_count, state_dbg
    );
    modport slave (
        input  en, w, overlap, clr_cnt,
        output z, z_reg, match_count, state_dbg
    );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised KMP serial pattern detector; SEQ_DET_STICKY_EN adds sticky seen flag
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input logic                 Clock,
    input logic                 Reset,
    seq_detector_param_if.slave bus
);
    localparam int SW = $clog2(PAT_LEN);

    // Pattern bit i counted in arrival order (i = 0 is the first bit received).
    function automatic int pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i] ? 1 : 0;
    endfunction

    // Bit i of the string "matched prefix of length s, then b".
    function automatic int seq_bit(input int s, input int b, input int i);
        return (i < s) ? pat_bit(i) : b;
    endfunction

    // Longest k < PAT_LEN such that the string's last k bits equal the pattern's first k.
    function automatic int fallback(input int s, input int b);
        int res;
        int lim;
        bit ok;
        res = 0;
        lim = (s + 1 < PAT_LEN - 1) ? s + 1 : PAT_LEN - 1;
        for (int k = 1; k <= lim; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (seq_bit(s, b, s + 1 - k + j) != pat_bit(j)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    // Longest proper border of the full pattern: where overlapping search resumes.
    function automatic int border();
        int res;
        bit ok;
        res = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pat_bit(PAT_LEN - k + j) != pat_bit(j)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    localparam logic [SW-1:0]    LAST    = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0]    BORDER  = SW'(border());
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SW-1:0] nxt_tbl [PAT_LEN][2];

    for (genvar s = 0; s < PAT_LEN; s++) begin : g_s
        for (genvar b = 0; b < 2; b++) begin : g_b
            localparam int NX = fallback(s, b);
            assign nxt_tbl[s][b] = SW'(NX);
        end
    end

    logic [SW-1:0]    state;
    logic [SW-1:0]    state_next;
    logic             hit;
    logic             z_int;
    logic             z_reg_q;
    logic [CNT_W-1:0] count_q;

    assign hit   = (state == LAST) && (bus.w == PATTERN[0]);
    assign z_int = bus.en & ~Reset & hit;

    always_comb begin
        state_next = state;
        if (bus.en) begin
            if (hit) begin
                state_next = bus.overlap ? BORDER : '0;
            end else begin
                state_next = nxt_tbl[state][bus.w];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= '0;
            z_reg_q <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            z_reg_q <= z_int;
            // A match in the clearing cycle still counts, so clear lands on 1.
            if (bus.clr_cnt) begin
                count_q <= z_int ? CNT_ONE : '0;
            end else if (z_int && count_q != CNT_MAX) begin
                count_q <= count_q + CNT_ONE;
            end
        end
    end

`ifdef SEQ_DET_STICKY_EN
    logic seen_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            seen_q <= 1'b0;
        end else if (bus.clr_cnt) begin
            seen_q <= 1'b0;
        end else if (z_int) begin
            seen_q <= 1'b1;
        end
    end

    assign bus.seen = seen_q;
`endif

    assign bus.z           = z_int;
    assign bus.z_reg       = z_reg_q;
    assign bus.match_count = count_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized and directed bench for seq_detector_param against a history-based model
module tb_seq_detector_param;
    localparam int             PAT_LEN = 4;
    localparam logic [3:0]     PATTERN = 4'b1101;
    localparam int             SW      = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic en_s = 1'b0, w_s = 1'b0, ov_s = 1'b0, clr_s = 1'b0;

    always #5 Clock = ~Clock;

    seq_detector_param_if #(.PAT_LEN(PAT_LEN), .CNT_W(8)) ifc_a ();
    seq_detector_param_if #(.PAT_LEN(PAT_LEN), .CNT_W(2)) ifc_b ();

    assign ifc_a.en = en_s;  assign ifc_a.w = w_s;  assign ifc_a.overlap = ov_s;  assign ifc_a.clr_cnt = clr_s;
    assign ifc_b.en = en_s;  assign ifc_b.w = w_s;  assign ifc_b.overlap = ov_s;  assign ifc_b.clr_cnt = clr_s;

    seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(8)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(ifc_a)
    );
    seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(ifc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: raw bit history plus how many trailing bits may still take part in a match.
    logic [63:0] hist;
    int          avail;
    int          cnt_a, cnt_b;
    bit          zr_exp, seen_exp;
    logic [31:0] zlog;

    function automatic bit suffix_is_prefix(input logic [63:0] h, input int k);
        for (int j = 0; j < k; j++) begin
            if (h[k-1-j] != PATTERN[PAT_LEN-1-j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_state();
        int lim;
        lim = (avail < PAT_LEN - 1) ? avail : PAT_LEN - 1;
        for (int k = lim; k > 0; k--) begin
            if (suffix_is_prefix(hist, k)) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        hist = '0; avail = 0; cnt_a = 0; cnt_b = 0; zr_exp = 0; seen_exp = 0; zlog = '0;
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Reset = 1'b1; en_s = 1'b0; w_s = 1'b0; ov_s = 1'b0; clr_s = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit e, input bit wv, input bit ov, input bit clr);
        logic [63:0] h2;
        bit          zx;
        int          ms;
        @(negedge Clock);
        en_s = e; w_s = wv; ov_s = ov; clr_s = clr;
        #1;
        h2 = {hist[62:0], wv};
        zx = e && (avail + 1 >= PAT_LEN) && suffix_is_prefix(h2, PAT_LEN);
        ms = model_state();
        n_vec++; if (ifc_a.z !== zx) begin n_err++; $display("FAIL z_a: got %b want %b", ifc_a.z, zx); end
        n_vec++; if (ifc_b.z !== zx) begin n_err++; $display("FAIL z_b: got %b want %b", ifc_b.z, zx); end
        n_vec++; if (ifc_a.state_dbg !== SW'(ms)) begin
            n_err++; $display("FAIL state_dbg: got %0d want %0d", ifc_a.state_dbg, ms);
        end
        @(posedge Clock);
        #1;
        if (e) begin
            hist = h2;
            avail++;
            if (zx && !ov) avail = 0;
        end
        if (clr) begin
            cnt_a = zx; cnt_b = zx;
        end else if (zx) begin
            if (cnt_a < 255) cnt_a++;
            if (cnt_b < 3) cnt_b++;
        end
        if (clr) seen_exp = 0; else if (zx) seen_exp = 1;
        zr_exp = zx;
        zlog   = {zlog[30:0], zx};
        n_vec++; if (ifc_a.z_reg !== zr_exp) begin n_err++; $display("FAIL z_reg: got %b want %b", ifc_a.z_reg, zr_exp); end
        n_vec++; if (ifc_a.match_count !== 8'(cnt_a)) begin
            n_err++; $display("FAIL count_a: got %0d want %0d", ifc_a.match_count, cnt_a);
        end
        n_vec++; if (ifc_b.match_count !== 2'(cnt_b)) begin
            n_err++; $display("FAIL count_b: got %0d want %0d", ifc_b.match_count, cnt_b);
        end
`ifdef SEQ_DET_STICKY_EN
        n_vec++; if (ifc_a.seen !== seen_exp) begin n_err++; $display("FAIL seen: got %b want %b", ifc_a.seen, seen_exp); end
`endif
    endtask

    task automatic run_bits(input logic [31:0] bits, input int n, input bit ov);
        logic [31:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], ov, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1; en_s = 1'b1; w_s = 1'b1;
        #1;
        n_vec++; if (ifc_a.z !== 1'b0) begin n_err++; $display("FAIL rst_z: got %b want 0", ifc_a.z); end
        n_vec++; if (ifc_a.z_reg !== 1'b0) begin n_err++; $display("FAIL rst_z_reg: got %b want 0", ifc_a.z_reg); end
        n_vec++; if (ifc_a.match_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", ifc_a.match_count); end
        n_vec++; if (ifc_a.state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", ifc_a.state_dbg); end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        run_bits(32'b1101, 4, 1'b0);
        n_vec++; if (zlog[3:0] !== 4'b0001) begin n_err++; $display("FAIL basic_z: got %b want 0001", zlog[3:0]); end
        n_vec++; if (ifc_a.match_count !== 8'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", ifc_a.match_count); end
`ifdef SEQ_DET_STICKY_EN
        n_vec++; if (ifc_a.seen !== 1'b1) begin n_err++; $display("FAIL basic_seen: got %b want 1", ifc_a.seen); end
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        apply_reset();
        run_bits(32'b1101101, 7, 1'b1);
        n_vec++; if (zlog[6:0] !== 7'b0001001) begin n_err++; $display("FAIL ovl_z: got %b want 0001001", zlog[6:0]); end
        n_vec++; if (ifc_a.match_count !== 8'd2) begin n_err++; $display("FAIL ovl_count: got %0d want 2", ifc_a.match_count); end
        apply_reset();
        run_bits(32'b1101101, 7, 1'b0);
        n_vec++; if (zlog[6:0] !== 7'b0001000) begin n_err++; $display("FAIL novl_z: got %b want 0001000", zlog[6:0]); end
        n_vec++; if (ifc_a.match_count !== 8'd1) begin n_err++; $display("FAIL novl_count: got %0d want 1", ifc_a.match_count); end
    endtask

    task automatic test_kmp();
        int exp_st [4] = '{1, 2, 2, 3};
        logic [4:0] bits = 5'b11101;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[4-i], 1'b0, 1'b0);
            if (i < 4) begin
                n_vec++; if (ifc_a.state_dbg !== SW'(exp_st[i])) begin
                    n_err++; $display("FAIL kmp_state%0d: got %0d want %0d", i, ifc_a.state_dbg, exp_st[i]);
                end
            end
        end
        n_vec++; if (zlog[4:0] !== 5'b00001) begin n_err++; $display("FAIL kmp_z1: got %b want 00001", zlog[4:0]); end
        apply_reset();
        run_bits(32'b101101, 6, 1'b0);
        n_vec++; if (zlog[5:0] !== 6'b000001) begin n_err++; $display("FAIL kmp_z2: got %b want 000001", zlog[5:0]); end
    endtask

    task automatic test_en_gating();
        apply_reset();
        run_bits(32'b11, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0], 1'b0, 1'b0);
            n_vec++; if (ifc_a.state_dbg !== 2'd2) begin n_err++; $display("FAIL gate_state: got %0d want 2", ifc_a.state_dbg); end
        end
        run_bits(32'b01, 2, 1'b0);
        n_vec++; if (zlog[6:0] !== 7'b0000001) begin n_err++; $display("FAIL gate_z: got %b want 0000001", zlog[6:0]); end
    endtask

    task automatic test_saturate();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        apply_reset();
        for (int m = 0; m < 5; m++) begin
            run_bits(32'b1101, 4, 1'b0);
            n_vec++; if (ifc_b.match_count !== 2'(exp_c[m])) begin
                n_err++; $display("FAIL sat%0d: got %0d want %0d", m, ifc_b.match_count, exp_c[m]);
            end
        end
        run_bits(32'b110, 3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_vec++; if (ifc_b.match_count !== 2'd1) begin n_err++; $display("FAIL clr_match: got %0d want 1", ifc_b.match_count); end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_vec++; if (ifc_b.match_count !== 2'd0) begin n_err++; $display("FAIL clr_alone: got %0d want 0", ifc_b.match_count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        run_bits(32'b1101, 4, 1'b0);
        run_bits(32'b110, 3, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        n_vec++; if (ifc_a.state_dbg !== 2'd0) begin n_err++; $display("FAIL arst_state: got %0d want 0", ifc_a.state_dbg); end
        n_vec++; if (ifc_a.match_count !== 8'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", ifc_a.match_count); end
`ifdef SEQ_DET_STICKY_EN
        n_vec++; if (ifc_a.seen !== 1'b0) begin n_err++; $display("FAIL arst_seen: got %b want 0", ifc_a.seen); end
`endif
        Reset = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (zlog[0] !== 1'b0) begin n_err++; $display("FAIL arst_z: got %b want 0", zlog[0]); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_bits(32'b1101101101, 10, 1'b1);
        n_vec++; if (zlog[9:0] !== 10'b0001001001) begin n_err++; $display("FAIL b2b_z: got %b want 0001001001", zlog[9:0]); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overlap();
        test_kmp();
        test_en_gating();
        test_saturate();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
